// File: rtl/tick_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : tick_scheduler_pkg
// Brief  : Shared state encoding, requester count and tick period helpers.
// Rev    : 1.0
// ============================================================================
package tick_scheduler_pkg;

  localparam int N_REQ = 4;
  localparam int REQ_W = 2;

  localparam int ST_W = 2;
  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int calc_period(input int clk_freq, input int tick_freq);
    return clk_freq / tick_freq;
  endfunction

  function automatic int calc_pw(input int period);
    return (period <= 2) ? 1 : $clog2(period);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_scheduler_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : tick_gen
// Brief  : Prescaler emitting a one-cycle tick every P cycles; clear restarts at 0.
// Rev    : 1.0
// ============================================================================
module tick_gen #(
  parameter int P  = 10,
  parameter int PW = 4
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [PW-1:0] LAST = PW'(P - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clear && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tick_scheduler
// Brief  : Round-robin arbiter granting one shared tick timer to four requesters.
// Rev    : 1.0
// ============================================================================
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int TICK_FREQ = 1_000,
  parameter int DUR_W     = 16
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DUR_W-1:0]   dur,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     busy
);

  localparam int P  = calc_period(CLK_FREQ, TICK_FREQ);
  localparam int PW = calc_pw(P);

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [DUR_W-1:0]    rem_q, rem_d;
  logic [REQ_W-1:0]    win_q, win_d;
  logic [REQ_W-1:0]    last_q, last_d;

  logic                w_tick;
  logic                w_clear;
  logic                w_found;
  logic [REQ_W-1:0]    w_win;
  logic [REQ_W-1:0]    w_idx;
  logic [N_REQ-1:0]    w_onehot;
  logic [DUR_W-1:0]    w_dur_sel;
  logic                w_abort;

  assign w_clear = (state_q != S_COUNT);

  tick_gen #(
    .P  (P),
    .PW (PW)
  ) u_tick_gen (
    .clk_in (clk_in),
    .reset  (reset),
    .clear  (w_clear),
    .tick   (w_tick)
  );

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = last_q;
    w_idx   = last_q;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = last_q + REQ_W'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_win] = 1'b1;
  end

  always_comb begin
    w_dur_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_q == REQ_W'(i)) begin
        w_dur_sel = dur[i*DUR_W +: DUR_W];
      end
    end
  end

  assign w_abort = ((state_q == S_LOAD) || (state_q == S_COUNT)) && !req[win_q];

  // State register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_found) state_d = S_LOAD;
      S_LOAD: begin
        if (w_abort)                state_d = S_IDLE;
        else if (w_dur_sel == '0)   state_d = S_DONE;
        else                        state_d = S_COUNT;
      end
      S_COUNT: begin
        if (w_abort)                                   state_d = S_IDLE;
        else if (w_tick && (rem_q == DUR_W'(1)))       state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE) ? grant_q : '0;
  end

  assign grant = grant_q;

  always_comb begin
    grant_d = grant_q;
    rem_d   = rem_q;
    win_d   = win_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          win_d   = w_win;
          grant_d = w_onehot;
        end
      end
      S_LOAD: begin
        rem_d = w_dur_sel;
        if (w_abort) begin
          grant_d = '0;
          last_d  = win_q;
        end
      end
      S_COUNT: begin
        if (w_abort) begin
          grant_d = '0;
          last_d  = win_q;
        end else if (w_tick) begin
          rem_d = rem_q - 1'b1;
        end
      end
      S_DONE: begin
        grant_d = '0;
        last_d  = win_q;
      end
      default: grant_d = '0;
    endcase
  end

  // Pointer resets to the top index so requester 0 is searched first.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      rem_q   <= '0;
      win_q   <= '0;
      last_q  <= REQ_W'(N_REQ - 1);
    end else begin
      grant_q <= grant_d;
      rem_q   <= rem_d;
      win_q   <= win_d;
      last_q  <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_tick_scheduler
// Brief  : Scoreboard bench for tick_scheduler with P = 10.
// Rev    : 1.0
// ============================================================================
module tb_tick_scheduler;

  localparam int DW = 16;

  logic          clk_in = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [4*DW-1:0] dur;
  logic [3:0]    grant;
  logic [3:0]    done;
  logic          busy;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;
  int c;

  tick_scheduler #(
    .CLK_FREQ  (100),
    .TICK_FREQ (10),
    .DUR_W     (DW)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .req    (req),
    .dur    (dur),
    .grant  (grant),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  function automatic exp_t mk(input int cy, input logic [3:0] v);
    exp_t e;
    e.cyc = cy;
    e.val = v;
    return e;
  endfunction

  // Monitor: pops an expectation whenever a done pulse appears
  always @(negedge clk_in) begin
    if (!reset) begin
      chk("grant_onehot_done_subset",
          {31'd0, $onehot0(grant) && ((done & ~grant) == 4'd0)}, 32'd1);
      if (done != 4'd0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", {28'd0, done}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("done_value", {28'd0, done}, {28'd0, mon_e.val});
          chk("done_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    req   = 4'd0;
    dur   = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_grant", {28'd0, grant}, 32'd0);
    chk("reset_done",  {28'd0, done},  32'd0);
    chk("reset_busy",  {31'd0, busy},  32'd0);
    @(negedge clk_in) reset = 1'b0;
    @(posedge clk_in);
    #1;

    // Single request, duration 3
    c = cyc;
    dur[0 +: DW] = 16'd3;
    req = 4'b0001;
    sb_q.push_back(mk(c + 32, 4'b0001));
    tick_to(c + 1);
    chk("single_grant", {28'd0, grant}, 32'd1);
    chk("single_busy",  {31'd0, busy},  32'd1);
    tick_to(c + 31);
    chk("single_grant_hold", {28'd0, grant}, 32'd1);
    tick_to(c + 32);
    req = 4'b0000;
    tick_to(c + 33);
    chk("single_idle_busy",  {31'd0, busy},  32'd0);
    chk("single_idle_grant", {28'd0, grant}, 32'd0);

    // Zero duration
    c = cyc;
    dur[2*DW +: DW] = 16'd0;
    req = 4'b0100;
    sb_q.push_back(mk(c + 2, 4'b0100));
    tick_to(c + 1);
    chk("zero_grant", {28'd0, grant}, 32'd4);
    tick_to(c + 2);
    req = 4'b0000;
    tick_to(c + 3);
    chk("zero_idle_busy", {31'd0, busy}, 32'd0);

    // Abort mid-count
    c = cyc;
    dur[1*DW +: DW] = 16'd5;
    req = 4'b0010;
    tick_to(c + 1);
    chk("abort_grant", {28'd0, grant}, 32'd2);
    tick_to(c + 20);
    req = 4'b0000;
    tick_to(c + 21);
    chk("abort_grant_cleared", {28'd0, grant}, 32'd0);
    chk("abort_busy",          {31'd0, busy},  32'd0);

    // Duration change during count is ignored
    c = cyc;
    dur[0 +: DW] = 16'd2;
    req = 4'b0001;
    sb_q.push_back(mk(c + 22, 4'b0001));
    tick_to(c + 5);
    dur[0 +: DW] = 16'd9;
    tick_to(c + 22);
    req = 4'b0000;
    tick_to(c + 23);
    chk("stable_idle_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-count
    c = cyc;
    dur[0 +: DW] = 16'd4;
    req = 4'b0001;
    tick_to(c + 15);
    #2 reset = 1'b1;
    #1;
    chk("areset_grant", {28'd0, grant}, 32'd0);
    chk("areset_done",  {28'd0, done},  32'd0);
    chk("areset_busy",  {31'd0, busy},  32'd0);
    req = 4'b0000;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) reset = 1'b0;
    @(posedge clk_in);
    #1;
    c = cyc;
    dur[0 +: DW]    = 16'd0;
    dur[3*DW +: DW] = 16'd0;
    req = 4'b1001;
    sb_q.push_back(mk(c + 2, 4'b0001));
    sb_q.push_back(mk(c + 5, 4'b1000));
    tick_to(c + 1);
    chk("post_reset_req0_wins", {28'd0, grant}, 32'd1);
    tick_to(c + 2);
    req = 4'b1000;
    tick_to(c + 4);
    chk("post_reset_req3_wins", {28'd0, grant}, 32'd8);
    tick_to(c + 5);
    req = 4'b0000;
    tick_to(c + 6);
    chk("post_reset_idle", {31'd0, busy}, 32'd0);

    // Round-robin fairness, all durations 1
    c = cyc;
    for (int i = 0; i < 4; i++) dur[i*DW +: DW] = 16'd1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      sb_q.push_back(mk(c + 12 + 13*k, 4'(1 << (k % 4))));
    end
    for (int k = 0; k < 5; k++) begin
      tick_to(c + 1 + 13*k);
      chk("rr_grant", {28'd0, grant}, 32'(1 << (k % 4)));
    end
    tick_to(c + 64);
    req = 4'b0000;
    tick_to(c + 66);
    chk("rr_idle_busy", {31'd0, busy}, 32'd0);

    repeat (5) @(posedge clk_in);
    #1;
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
